// File: rtl/mem_arb_pkg.sv
// Shared types and counter widths for the single-port RAM arbiter.
// The saturating increment keeps the fetch anti-starvation streak bounded.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int WAIT_W   = 4;
    localparam int STREAK_W = 4;

    function automatic logic [STREAK_W-1:0] streak_sat_inc(
        input logic [STREAK_W-1:0] cur,
        input logic [STREAK_W-1:0] lim
    );
        logic [STREAK_W-1:0] nxt;
        if (cur >= lim) begin
            nxt = lim;
        end else begin
            nxt = cur + {{(STREAK_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/ack bundle for the fetch and load/store paths plus the RAM side.
// The arbiter uses the slave modport; requesters and the RAM model use master.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    import mem_arb_pkg::*;

    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ack;
    logic [31:0]       f_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_be;
    logic              d_ack;
    logic [31:0]       d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        output f_ack, f_rdata, d_ack, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        input  f_ack, f_rdata, d_ack, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/arb_pick.sv
// Combinational grant: data wins unless fetch has waited MAX_STREAK data grants.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic                f_req,
    input  logic                d_req,
    input  logic [STREAK_W-1:0] streak,
    output owner_t              grant,
    output logic                valid
);

    localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_STREAK);

    // Priority decode with the starvation override for fetch.
    always_comb begin
        grant = OWN_D;
        valid = 1'b0;
        if (d_req && !(f_req && (streak == MAX_S))) begin
            grant = OWN_D;
            valid = 1'b1;
        end else if (f_req) begin
            grant = OWN_F;
            valid = 1'b1;
        end else begin
            grant = OWN_D;
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store.
// Each access: IDLE (arbitrate) -> ACCESS (WAIT_STATES+1 cycles) -> DONE (ack).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 1,
    parameter int MAX_STREAK  = 4
) (
    input  logic          Clock,
    input  logic          nReset,
    mem_arbiter_if.slave  bus,
    output logic          busy
);

    localparam logic [WAIT_W-1:0]   WAIT_INIT = WAIT_W'(WAIT_STATES);
    localparam logic [STREAK_W-1:0] MAX_S     = STREAK_W'(MAX_STREAK);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic                f_ack_q, f_ack_d;
    logic                d_ack_q, d_ack_d;
    logic [31:0]         f_rdata_q, f_rdata_d;
    logic [31:0]         d_rdata_q, d_rdata_d;

    owner_t              pick_owner_s;
    logic                pick_valid_s;

    arb_pick #(
        .MAX_STREAK (MAX_STREAK)
    ) u_pick (
        .f_req  (bus.f_req),
        .d_req  (bus.d_req),
        .streak (streak_q),
        .grant  (pick_owner_s),
        .valid  (pick_valid_s)
    );

    // Next-state and output-register computation for the access sequencer.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wait_d      = wait_q;
        streak_d    = streak_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        f_ack_d     = f_ack_q;
        d_ack_d     = d_ack_q;
        f_rdata_d   = f_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    owner_d  = pick_owner_s;
                    mem_en_d = 1'b1;
                    wait_d   = WAIT_INIT;
                    state_d  = ACCESS;
                    if (pick_owner_s == OWN_D) begin
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_we ? bus.d_wdata : 32'h0000_0000;
                        mem_be_d    = bus.d_be;
                        streak_d    = bus.f_req ? streak_sat_inc(streak_q, MAX_S)
                                                : {STREAK_W{1'b0}};
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.f_addr;
                        mem_wdata_d = 32'h0000_0000;
                        mem_be_d    = 4'hF;
                        streak_d    = {STREAK_W{1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (wait_q != {WAIT_W{1'b0}}) begin
                    wait_d = wait_q - {{(WAIT_W-1){1'b0}}, 1'b1};
                end else begin
                    // Stores leave both rdata registers untouched.
                    if (!mem_we_q && (owner_q == OWN_D)) begin
                        d_rdata_d = bus.mem_rdata;
                    end else if (!mem_we_q) begin
                        f_rdata_d = bus.mem_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                    if (owner_q == OWN_D) begin
                        d_ack_d = 1'b1;
                    end else begin
                        f_ack_d = 1'b1;
                    end
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                f_ack_d = 1'b0;
                d_ack_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                f_ack_d  = 1'b0;
                d_ack_d  = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops mem_en and aborts any access.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_F;
            wait_q      <= {WAIT_W{1'b0}};
            streak_q    <= {STREAK_W{1'b0}};
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= 32'h0000_0000;
            mem_be_q    <= 4'h0;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            f_rdata_q   <= 32'h0000_0000;
            d_rdata_q   <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wait_q      <= wait_d;
            streak_q    <= streak_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            f_ack_q     <= f_ack_d;
            d_ack_q     <= d_ack_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.f_ack     = f_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.f_rdata   = f_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences and random
// traffic, all checked against a transaction-timeline model and a shadow RAM.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int WS     = 1;
    localparam int MAXS   = 4;

    logic Clock = 1'b0;
    logic nReset;
    logic busy;
    logic ram_init;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .WAIT_STATES(WS), .MAX_STREAK(MAXS)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus),
        .busy   (busy)
    );

    always #5 Clock = ~Clock;

    function automatic logic [31:0] init_word(input int i);
        return (i == 16) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(i));
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // RAM model driven purely by the DUT's mem_* outputs.
    logic [31:0] ram [0:255];
    assign bus.mem_rdata = ram[bus.mem_addr[9:2]];
    always @(posedge Clock) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else if (bus.mem_en && bus.mem_we) begin
            ram[bus.mem_addr[9:2]] <= merge_be(ram[bus.mem_addr[9:2]], bus.mem_wdata, bus.mem_be);
        end
    end

    int n_vec, n_err, cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase = cycles since the grant edge, 0 when idle.
    logic [31:0] ref_mem [0:255];
    int          ph, streak_m;
    logic        own_d_m, t_we;
    logic [31:0] t_addr, t_wdata, exp_f_rdata, exp_d_rdata;
    logic [3:0]  t_be;

    task automatic model_reset();
        ph = 0; streak_m = 0; own_d_m = 1'b0;
        exp_f_rdata = 32'h0; exp_d_rdata = 32'h0;
    endtask

    task automatic model_update();
        if (ph == 0) begin
            if (bus.f_req || bus.d_req) begin
                own_d_m = bus.d_req && !(bus.f_req && streak_m == MAXS);
                if (own_d_m) begin
                    streak_m = bus.f_req ? ((streak_m < MAXS) ? streak_m + 1 : MAXS) : 0;
                    t_addr = bus.d_addr; t_we = bus.d_we; t_be = bus.d_be;
                    t_wdata = bus.d_we ? bus.d_wdata : 32'h0;
                end else begin
                    streak_m = 0;
                    t_addr = bus.f_addr; t_we = 1'b0; t_be = 4'hF; t_wdata = 32'h0;
                end
                ph = 1;
            end
        end else if (ph == WS + 2) begin
            ph = 0;
        end else begin
            if (ph == WS + 1) begin
                if (t_we) ref_mem[t_addr[9:2]] = merge_be(ref_mem[t_addr[9:2]], t_wdata, t_be);
                else if (own_d_m) exp_d_rdata = ref_mem[t_addr[9:2]];
                else exp_f_rdata = ref_mem[t_addr[9:2]];
            end
            ph++;
        end
    endtask

    task automatic check_all();
        bit exp_en;
        exp_en = (ph >= 1) && (ph <= WS + 1);
        chk("busy", 32'(busy), 32'(ph != 0));
        chk("mem_en", 32'(bus.mem_en), 32'(exp_en));
        if (exp_en) begin
            chk("mem_addr", bus.mem_addr, t_addr);
            chk("mem_we", 32'(bus.mem_we), 32'(t_we));
            chk("mem_wdata", bus.mem_wdata, t_wdata);
            if (t_we || !own_d_m) chk("mem_be", 32'(bus.mem_be), 32'(t_be));
        end else begin
            chk("mem_we_off", 32'(bus.mem_we), 32'd0);
        end
        chk("f_ack", 32'(bus.f_ack), 32'(ph == WS + 2 && !own_d_m));
        chk("d_ack", 32'(bus.d_ack), 32'(ph == WS + 2 && own_d_m));
        chk("f_rdata", bus.f_rdata, exp_f_rdata);
        chk("d_rdata", bus.d_rdata, exp_d_rdata);
    endtask

    task automatic edge_model();
        @(posedge Clock);
        if (nReset) model_update(); else model_reset();
        #1;
    endtask

    task automatic sample();
        @(negedge Clock);
        cyc++;
        check_all();
    endtask

    task automatic new_f();
        bus.f_req = 1'b1; bus.f_addr = $urandom() & 32'hFFFF_FFFC;
    endtask

    task automatic new_d();
        bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = $urandom() & 32'hFFFF_FFFC; bus.d_wdata = $urandom();
        bus.d_be = 4'($urandom_range(0, 15));
    endtask

    bit ack_log[$];
    int ack_cyc[$];

    // Each requester holds req until its ack, then renews or drops it.
    task automatic run_reqs(input int nf, input int nd, input bit rnd, input int budget);
        int  f_left, d_left, c;
        bit  f_act, d_act, fa, da;
        f_left = nf; d_left = nd; c = 0;
        f_act = 1'b0; d_act = 1'b0; fa = 1'b0; da = 1'b0;
        ack_log.delete(); ack_cyc.delete();
        while ((f_left > 0 || d_left > 0 || f_act || d_act || busy) && c < budget) begin
            edge_model();
            if (f_act && fa) f_act = 1'b0;
            if (d_act && da) d_act = 1'b0;
            if (!f_act) begin
                if (f_left > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
                    new_f(); f_act = 1'b1; f_left--;
                end else bus.f_req = 1'b0;
            end
            if (!d_act) begin
                if (d_left > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
                    new_d(); d_act = 1'b1; d_left--;
                end else bus.d_req = 1'b0;
            end
            sample();
            fa = bus.f_ack; da = bus.d_ack;
            if (fa) begin ack_log.push_back(1'b0); ack_cyc.push_back(cyc); end
            if (da) begin ack_log.push_back(1'b1); ack_cyc.push_back(cyc); end
            c++;
        end
        chk("run_timeout", 32'(c >= budget), 32'd0);
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];
    bit   exp_order [10];

    initial begin
        int   lat, en_cnt;
        bit   got, ack_d, seen_we;
        logic [31:0] rd, seen_wd;
        logic [3:0]  seen_be;

        vecs[0] = '{1'b0, 1'b0, 32'h040, 32'h0,         4'hF,    4'hF,    32'h0,         32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h100, 32'h1234_5678, 4'b0011, 4'b0011, 32'h1234_5678, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h100, 32'hFFFF_FFFF, 4'hF,    4'hF,    32'h0,         32'hC0DE_5678};
        vecs[3] = '{1'b1, 1'b1, 32'h104, 32'hAABB_CCDD, 4'b1100, 4'b1100, 32'hAABB_CCDD, 32'hC0DE_5678};
        vecs[4] = '{1'b0, 1'b0, 32'h104, 32'h0,         4'hF,    4'hF,    32'h0,         32'hAABB_0041};
        vecs[5] = '{1'b1, 1'b0, 32'h040, 32'h0,         4'hF,    4'hF,    32'h0,         32'hDEAD_BEEF};
        vecs[6] = '{1'b1, 1'b1, 32'h040, 32'h0BAD_F00D, 4'b1001, 4'b1001, 32'h0BAD_F00D, 32'hDEAD_BEEF};
        vecs[7] = '{1'b0, 1'b0, 32'h040, 32'h0,         4'hF,    4'hF,    32'h0,         32'h0BAD_BE0D};
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        n_vec = 0; n_err = 0; cyc = 0;
        nReset = 1'b0; ram_init = 1'b1;
        bus.f_req = 1'b0; bus.f_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0; bus.d_be = 4'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        model_reset();

        // Reset held, then released with no requests.
        repeat (3) begin edge_model(); ram_init = 1'b0; sample(); end
        edge_model(); nReset = 1'b1; sample();
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
        repeat (5) begin edge_model(); sample(); end

        // Table of isolated transactions.
        for (int i = 0; i < 8; i++) begin
            edge_model();
            if (vecs[i].is_d) begin
                bus.d_req = 1'b1; bus.d_we = vecs[i].we; bus.d_addr = vecs[i].addr;
                bus.d_wdata = vecs[i].wdata; bus.d_be = vecs[i].be;
            end else begin
                bus.f_req = 1'b1; bus.f_addr = vecs[i].addr;
            end
            sample();
            lat = 0; en_cnt = 0; got = 1'b0; ack_d = 1'b0; rd = 32'h0;
            seen_we = 1'b0; seen_wd = 32'h0; seen_be = 4'h0;
            for (int c = 1; c <= 20 && !got; c++) begin
                edge_model(); sample();
                if (bus.mem_en) begin
                    en_cnt++; seen_we = bus.mem_we; seen_wd = bus.mem_wdata; seen_be = bus.mem_be;
                end
                if (bus.f_ack || bus.d_ack) begin
                    got = 1'b1; lat = c; ack_d = bus.d_ack;
                    rd = bus.d_ack ? bus.d_rdata : bus.f_rdata;
                end
            end
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(WS + 2));
            chk($sformatf("tbl%0d_en_cycles", i), 32'(en_cnt), 32'(WS + 1));
            chk($sformatf("tbl%0d_owner", i), 32'(ack_d), 32'(vecs[i].is_d));
            chk($sformatf("tbl%0d_mem_we", i), 32'(seen_we), 32'(vecs[i].is_d & vecs[i].we));
            chk($sformatf("tbl%0d_mem_be", i), 32'(seen_be), 32'(vecs[i].exp_be));
            chk($sformatf("tbl%0d_mem_wdata", i), seen_wd, vecs[i].exp_wdata);
            chk($sformatf("tbl%0d_rdata", i), rd, vecs[i].exp_rdata);
            edge_model(); bus.f_req = 1'b0; bus.d_req = 1'b0; sample();
            edge_model(); sample();
        end

        // Continuous contention: fetch gets one slot after MAXS data grants.
        run_reqs(2, 8, 1'b0, 200);
        chk("order_len", 32'(ack_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < ack_log.size(); i++)
            chk($sformatf("order%0d", i), 32'(ack_log[i]), 32'(exp_order[i]));

        // Both rise together with streak 0: D first, F in the IDLE after D's DONE.
        edge_model(); sample();
        run_reqs(1, 1, 1'b0, 100);
        chk("simul_len", 32'(ack_log.size()), 32'd2);
        if (ack_log.size() == 2) begin
            chk("simul_first_d", 32'(ack_log[0]), 32'd1);
            chk("simul_gap", 32'(ack_cyc[1] - ack_cyc[0]), 32'(WS + 3));
        end

        // Reset asserted during the second ACCESS cycle of a load.
        edge_model();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0040; bus.d_be = 4'hF;
        sample();
        edge_model(); sample();
        edge_model(); sample();
        chk("pre_reset_en", 32'(bus.mem_en), 32'd1);
        #1 nReset = 1'b0;
        #1 model_reset();
        chk("midrst_mem_en", 32'(bus.mem_en), 32'd0);
        check_all();
        edge_model(); nReset = 1'b1; sample();
        got = 1'b0; lat = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            edge_model(); sample();
            if (bus.d_ack) begin got = 1'b1; lat = c; end
        end
        chk("rearb_latency", 32'(lat), 32'(WS + 2));
        edge_model(); bus.d_req = 1'b0; sample();
        edge_model(); sample();

        // Random traffic against the model.
        run_reqs(60, 60, 1'b1, 5000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
